clus_ofc_err_tx: RTL and testbench

//  Serial transmitter for the cluster/OFC TLK error link, the sending end of the error-bus receiver.

---
 rtl/clus_ofc_err_tx.sv | 156 +++++++++++++++
 tb/tb_clus_ofc_err_tx.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/clus_ofc_err_tx.sv
// Serial error-word transmitter: header 1,0,0 then LENGTH_ERR data bits LSB first, then a low gap.
// Optional even-parity bit after the data when CLUS_OFC_ERR_TX_PARITY_EN is defined.
module clus_ofc_err_tx #(
  parameter int unsigned LENGTH_ERR = 18,
  parameter int unsigned IDLE_GAP   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_live,
  input  logic                  tx_valid,
  input  logic [LENGTH_ERR-1:0] tx_data,
  output logic                  tx_ready,
  output logic                  out_err,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int unsigned DW = $clog2(LENGTH_ERR + 1);
  localparam int unsigned GW = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
    S_PAR,
    S_GAP
  } state_t;

  state_t                state_q, state_d;
  logic [LENGTH_ERR-1:0] sreg_q, sreg_d;
  logic [1:0]            hdr_cnt_q, hdr_cnt_d;
  logic [DW-1:0]         data_cnt_q, data_cnt_d;
  logic [GW-1:0]         gap_cnt_q, gap_cnt_d;
  logic                  out_err_q, out_err_d;
  logic                  frame_done_q, frame_done_d;
  logic                  live_q, live_d;
  logic                  accept;
`ifdef CLUS_OFC_ERR_TX_PARITY_EN
  logic                  par_q, par_d;
`endif

  // Registered in_live gates acceptance, so a word cannot start on the edge the link comes up.
  assign tx_ready   = (state_q == S_IDLE) & in_live & live_q & ~rst;
  assign accept     = tx_valid & tx_ready;
  assign out_err    = out_err_q;
  assign frame_done = frame_done_q;
  assign busy       = (state_q != S_IDLE);
  assign live_d     = in_live;

  always_comb begin
    state_d      = state_q;
    sreg_d       = sreg_q;
    hdr_cnt_d    = hdr_cnt_q;
    data_cnt_d   = data_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    out_err_d    = 1'b0;
    frame_done_d = 1'b0;
`ifdef CLUS_OFC_ERR_TX_PARITY_EN
    par_d        = par_q;
`endif
    if (!in_live) begin
      state_d    = S_IDLE;
      hdr_cnt_d  = '0;
      data_cnt_d = '0;
      gap_cnt_d  = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            state_d   = S_HDR;
            out_err_d = 1'b1;
            sreg_d    = tx_data;
            hdr_cnt_d = '0;
`ifdef CLUS_OFC_ERR_TX_PARITY_EN
            par_d     = ^tx_data;
`endif
          end
        end
        S_HDR: begin
          // The last header edge already drives D0 so data follows the header with no gap.
          if (hdr_cnt_q == 2'd2) begin
            state_d    = S_DATA;
            out_err_d  = sreg_q[0];
            sreg_d     = sreg_q >> 1;
            data_cnt_d = '0;
          end else begin
            hdr_cnt_d = hdr_cnt_q + 2'd1;
          end
        end
        S_DATA: begin
          if (data_cnt_q == DW'(LENGTH_ERR - 1)) begin
`ifdef CLUS_OFC_ERR_TX_PARITY_EN
            state_d      = S_PAR;
            out_err_d    = par_q;
`else
            state_d      = S_GAP;
            frame_done_d = 1'b1;
            gap_cnt_d    = '0;
`endif
          end else begin
            out_err_d  = sreg_q[0];
            sreg_d     = sreg_q >> 1;
            data_cnt_d = data_cnt_q + DW'(1);
          end
        end
        S_PAR: begin
          state_d      = S_GAP;
          frame_done_d = 1'b1;
          gap_cnt_d    = '0;
        end
        S_GAP: begin
          if (gap_cnt_q == GW'(IDLE_GAP - 1)) begin
            state_d   = S_IDLE;
            gap_cnt_d = '0;
          end else begin
            gap_cnt_d = gap_cnt_q + GW'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      sreg_q       <= '0;
      hdr_cnt_q    <= '0;
      data_cnt_q   <= '0;
      gap_cnt_q    <= '0;
      out_err_q    <= 1'b0;
      frame_done_q <= 1'b0;
      live_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sreg_q       <= sreg_d;
      hdr_cnt_q    <= hdr_cnt_d;
      data_cnt_q   <= data_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      out_err_q    <= out_err_d;
      frame_done_q <= frame_done_d;
      live_q       <= live_d;
    end
  end

`ifdef CLUS_OFC_ERR_TX_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end
`endif

endmodule

// File: tb/tb_clus_ofc_err_tx.sv
// Directed bench for clus_ofc_err_tx: table of frames plus reset, back-to-back and abort sequences.
module tb_clus_ofc_err_tx;

  localparam int L = 18;
  localparam int G = 3;
`ifdef CLUS_OFC_ERR_TX_PARITY_EN
  localparam int FD_CYC = 23;
`else
  localparam int FD_CYC = 22;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_live = 1'b0;
  logic          tx_valid = 1'b0;
  logic [L-1:0]  tx_data = '0;
  logic          tx_ready, out_err, busy, frame_done;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  clus_ofc_err_tx #(.LENGTH_ERR(L), .IDLE_GAP(G)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_live   (in_live),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .out_err   (out_err),
    .busy      (busy),
    .frame_done(frame_done)
  );

  typedef struct {
    logic [L-1:0] data;
    logic [20:0]  seq;   // line bits after accept, index 0 first
    logic         par;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_idle(input string tag);
    int t = 0;
    while (!(tx_ready && !busy) && t < 60) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_idle"}, {31'd0, tx_ready & ~busy}, 32'd1);
  endtask

  task automatic send_frame(input vec_t v, input string tag);
    wait_idle(tag);
    tx_valid = 1'b1;
    tx_data  = v.data;
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data  = '0;
    for (int k = 0; k < 21; k++) begin
      chk({tag, "_bit"}, {31'd0, out_err}, {31'd0, v.seq[k]});
      chk({tag, "_fd_low"}, {31'd0, frame_done}, 32'd0);
      chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
      @(negedge clk);
    end
`ifdef CLUS_OFC_ERR_TX_PARITY_EN
    chk({tag, "_par"}, {31'd0, out_err}, {31'd0, v.par});
    chk({tag, "_par_fd"}, {31'd0, frame_done}, 32'd0);
    @(negedge clk);
`endif
    chk({tag, "_fd"}, {31'd0, frame_done}, 32'd1);
    chk({tag, "_gap0"}, {31'd0, out_err}, 32'd0);
    for (int g = 1; g < G; g++) begin
      @(negedge clk);
      chk({tag, "_gap_fd"}, {31'd0, frame_done}, 32'd0);
      chk({tag, "_gap_line"}, {31'd0, out_err}, 32'd0);
      chk({tag, "_gap_busy"}, {31'd0, busy}, 32'd1);
    end
    @(negedge clk);
    chk({tag, "_end_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_end_ready"}, {31'd0, tx_ready}, 32'd1);
  endtask

  initial begin
    int   fd_c, h2, ready_hits, fd_hits, cyc;
    logic [20:0] seq2;

    vecs[0] = '{18'h2A5C3, 21'b101010010111000011001, 1'b1};
    vecs[1] = '{18'h00003, {18'h00003, 3'b001}, 1'b0};
    vecs[2] = '{18'h3FFFF, {18'h3FFFF, 3'b001}, 1'b0};
    vecs[3] = '{18'h00000, {18'h00000, 3'b001}, 1'b0};
    vecs[4] = '{18'h20000, {18'h20000, 3'b001}, 1'b1};
    vecs[5] = '{18'h15555, {18'h15555, 3'b001}, 1'b1};

    // Reset state
    #1 rst = 1'b1;
    #2;
    chk("rst_out_err", {31'd0, out_err}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_fd", {31'd0, frame_done}, 32'd0);
    chk("rst_ready", {31'd0, tx_ready}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst     = 1'b0;
    in_live = 1'b1;
    chk("live_first_ready", {31'd0, tx_ready}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("post_rst_ready", {31'd0, tx_ready}, 32'd1);

    // Table of single frames
    for (int i = 0; i < 6; i++) send_frame(vecs[i], "frame");

    // Reset mid-frame, checked before any further clock edge
    wait_idle("rstmid");
    tx_valid = 1'b1;
    tx_data  = 18'h2A5C3;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rstmid_d0", {31'd0, out_err}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rstmid_out_err", {31'd0, out_err}, 32'd0);
    chk("rstmid_busy", {31'd0, busy}, 32'd0);
    chk("rstmid_fd", {31'd0, frame_done}, 32'd0);
    chk("rstmid_ready", {31'd0, tx_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rstmid_rel_ready", {31'd0, tx_ready}, 32'd1);

    // Back-to-back with tx_valid held high
    wait_idle("b2b");
    tx_valid = 1'b1;
    tx_data  = 18'h00001;
    @(negedge clk);
    tx_data    = 18'h20000;
    cyc        = 1;
    fd_c       = -1;
    h2         = -1;
    ready_hits = 0;
    for (int t = 0; t < 60; t++) begin
      if (h2 < 0 && tx_ready) ready_hits++;
      if (fd_c < 0 && frame_done) fd_c = cyc;
      if (fd_c >= 0 && h2 < 0 && out_err) h2 = cyc;
      if (h2 >= 0) break;
      @(negedge clk);
      cyc++;
    end
    tx_valid = 1'b0;
    chk("b2b_fd_cycle", fd_c, FD_CYC);
    chk("b2b_hdr_spacing", h2 - fd_c, G + 1);
    chk("b2b_ready_once", ready_hits, 1);
    seq2 = {18'h20000, 3'b001};
    for (int k = 0; k < 21; k++) begin
      chk("b2b_frame2_bit", {31'd0, out_err}, {31'd0, seq2[k]});
      @(negedge clk);
    end
    wait_idle("b2b_end");

    // Abort during D7, then link re-enable together with tx_valid
    tx_valid = 1'b1;
    tx_data  = 18'h2A5C3;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("abort_d7", {31'd0, out_err}, 32'd1);
    in_live = 1'b0;
    #1;
    chk("abort_ready_now", {31'd0, tx_ready}, 32'd0);
    @(negedge clk);
    chk("abort_line", {31'd0, out_err}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    fd_hits    = 0;
    ready_hits = 0;
    for (int t = 0; t < 25; t++) begin
      if (frame_done) fd_hits++;
      if (tx_ready) ready_hits++;
      @(negedge clk);
    end
    chk("abort_no_fd", fd_hits, 0);
    chk("abort_no_ready", ready_hits, 0);
    tx_valid = 1'b1;
    tx_data  = 18'h15555;
    in_live  = 1'b1;
    #1;
    chk("relive_ready_low", {31'd0, tx_ready}, 32'd0);
    @(negedge clk);
    chk("relive_no_accept", {31'd0, busy}, 32'd0);
    chk("relive_ready", {31'd0, tx_ready}, 32'd1);
    @(negedge clk);
    tx_valid = 1'b0;
    chk("relive_accept", {31'd0, busy}, 32'd1);
    chk("relive_hdr", {31'd0, out_err}, 32'd1);
    wait_idle("relive_end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
